// File: rtl/if_id_fifo.sv
// Purpose: elastic IF/ID buffer holding up to DEPTH {instruction, PC+4} pairs between fetch and decode.
// Latency: one cycle from ihit to instr/out_valid, no bypass; sustains one instruction per cycle.
// Backpressure: in_ready drops when full (registered state only); stall holds the head; flush empties next edge.
module if_id_fifo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 2,
    parameter logic [DATA_W-1:0] NOP = '0,
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ihit,
    input  logic [DATA_W-1:0] imemload,
    input  logic [DATA_W-1:0] pcp4_in,
    input  logic              flush,
    input  logic              stall,
    output logic [DATA_W-1:0] instr,
    output logic [DATA_W-1:0] pcp4_out,
    output logic              out_valid,
    output logic              in_ready,
    output logic [CNT_W-1:0]  count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    // Storage is deliberately not reset: cnt alone decides what is live.
    logic [DATA_W-1:0] instr_mem [DEPTH];
    logic [DATA_W-1:0] pcp4_mem  [DEPTH];

    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [CNT_W-1:0] cnt;

    logic enq;
    logic deq;

    // Flow-control flags come from registered occupancy only, so stall
    // never reaches in_ready combinationally.
    always_comb begin
        in_ready  = (cnt != CNT_W'(DEPTH));
        out_valid = (cnt != '0);
        enq       = ihit & in_ready & ~flush;
        deq       = out_valid & ~stall & ~flush;
    end

    // Head presentation: a NOP bubble with zero PC+4 whenever nothing is buffered.
    always_comb begin
        instr    = NOP;
        pcp4_out = '0;
        if (out_valid) begin
            instr    = instr_mem[rptr];
            pcp4_out = pcp4_mem[rptr];
        end
        count = cnt;
    end

    // Write the fetched pair into the slot at the write pointer.
    always_ff @(posedge CLK) begin
        if (enq) begin
            instr_mem[wptr] <= imemload;
            pcp4_mem[wptr]  <= pcp4_in;
        end
    end

    // Pointer and occupancy bookkeeping; flush outranks any enq/deq.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (enq) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (deq) begin
                rptr <= rptr + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_if_id_fifo.sv
// Bench for if_id_fifo: a DEPTH=2 and a DEPTH=4 instance share clock, reset, data, stall and flush.
// Each instance has its own ihit; a queue per instance holds the words expected on its output.
// Scenario tasks drive stimulus and compare DUT outputs against the queue heads inline.
module tb_if_id_fifo;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        ihit2 = 1'b0;
    logic        ihit4 = 1'b0;
    logic [31:0] imemload = '0;
    logic [31:0] pcp4_in = '0;
    logic        flush = 1'b0;
    logic        stall = 1'b0;

    logic [31:0] instr2, pc2, instr4, pc4;
    logic        vld2, rdy2, vld4, rdy4;
    logic [1:0]  cnt2;
    logic [2:0]  cnt4;

    logic [63:0] q2[$];
    logic [63:0] q4[$];

    int nchk = 0;
    int npass = 0;

    always #5 CLK = ~CLK;

    if_id_fifo #(.DATA_W(32), .DEPTH(2)) u2 (
        .CLK(CLK), .nRST(nRST), .ihit(ihit2), .imemload(imemload), .pcp4_in(pcp4_in),
        .flush(flush), .stall(stall), .instr(instr2), .pcp4_out(pc2),
        .out_valid(vld2), .in_ready(rdy2), .count(cnt2)
    );

    if_id_fifo #(.DATA_W(32), .DEPTH(4)) u4 (
        .CLK(CLK), .nRST(nRST), .ihit(ihit4), .imemload(imemload), .pcp4_in(pcp4_in),
        .flush(flush), .stall(stall), .instr(instr4), .pcp4_out(pc4),
        .out_valid(vld4), .in_ready(rdy4), .count(cnt4)
    );

    // Advance one clock: the scoreboards accept/retire words exactly as the
    // interface contract says, using their own fill level, then wait for the edge.
    task automatic tick();
        bit d2, e2, d4, e4;
        d2 = (q2.size() != 0) && !stall && !flush;
        e2 = ihit2 && (q2.size() < 2) && !flush;
        d4 = (q4.size() != 0) && !stall && !flush;
        e4 = ihit4 && (q4.size() < 4) && !flush;
        @(posedge CLK);
        if (flush || !nRST) begin
            q2.delete();
            q4.delete();
        end else begin
            if (d2) void'(q2.pop_front());
            if (e2) q2.push_back({imemload, pcp4_in});
            if (d4) void'(q4.pop_front());
            if (e4) q4.push_back({imemload, pcp4_in});
        end
        #1;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        nchk++; if (vld2 !== 1'b0 || rdy2 !== 1'b1) begin
            $display("FAIL rst_hold vld=%0b rdy=%0b want 0/1", vld2, rdy2);
        end else npass++;
        nRST = 1'b1;
        for (int c = 0; c < 5; c++) begin
            nchk++; if (instr2 !== 32'h0 || pc2 !== 32'h0) begin
                $display("FAIL idle_data c=%0d instr=%h pcp4=%h want 0/0", c, instr2, pc2);
            end else npass++;
            nchk++; if (vld2 !== 1'b0 || rdy2 !== 1'b1 || cnt2 !== 2'd0) begin
                $display("FAIL idle_flags c=%0d vld=%0b rdy=%0b cnt=%0d want 0/1/0", c, vld2, rdy2, cnt2);
            end else npass++;
            nchk++; if (vld4 !== 1'b0 || rdy4 !== 1'b1 || cnt4 !== 3'd0 || instr4 !== 32'h0) begin
                $display("FAIL idle4 c=%0d vld=%0b rdy=%0b cnt=%0d instr=%h", c, vld4, rdy4, cnt4, instr4);
            end else npass++;
            tick();
        end
    endtask

    task automatic test_stream();
        logic [63:0] h;
        stall = 1'b0;
        for (int k = 0; k < 12; k++) begin
            ihit2 = 1'b1;
            imemload = 32'h2000_0001 + k;
            pcp4_in = 32'd4 + 32'd4 * k;
            if (k == 0) begin
                nchk++; if (vld2 !== 1'b0) begin
                    $display("FAIL stream_bypass vld=%0b want 0", vld2);
                end else npass++;
            end else begin
                h = q2[0];
                nchk++; if (vld2 !== 1'b1 || instr2 !== h[63:32] || pc2 !== h[31:0]) begin
                    $display("FAIL stream_data k=%0d vld=%0b instr=%h pcp4=%h want 1/%h/%h", k, vld2, instr2, pc2, h[63:32], h[31:0]);
                end else npass++;
                nchk++; if (cnt2 !== 2'd1 || h[63:32] !== 32'h2000_0001 + k - 1) begin
                    $display("FAIL stream_cnt k=%0d cnt=%0d want 1 (head %h)", k, cnt2, h[63:32]);
                end else npass++;
            end
            tick();
        end
        ihit2 = 1'b0;
        h = q2[0];
        nchk++; if (instr2 !== 32'h2000_000c || pc2 !== h[31:0]) begin
            $display("FAIL stream_last instr=%h pcp4=%h want 2000000c/%h", instr2, pc2, h[31:0]);
        end else npass++;
        tick();
        nchk++; if (vld2 !== 1'b0 || instr2 !== 32'h0 || cnt2 !== 2'd0) begin
            $display("FAIL stream_drain vld=%0b instr=%h cnt=%0d want 0/0/0", vld2, instr2, cnt2);
        end else npass++;
    endtask

    task automatic test_stall_fill();
        logic [31:0] words [3];
        words[0] = 32'hAAAA_0001; words[1] = 32'hBBBB_0002; words[2] = 32'hCCCC_0003;
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ihit2 = 1'b1;
            imemload = words[k];
            pcp4_in = 32'h100 + 32'd4 * k;
            tick();
            nchk++; if (cnt2 !== 2'(q2.size()) || rdy2 !== (q2.size() < 2)) begin
                $display("FAIL fill_cnt k=%0d cnt=%0d rdy=%0b want %0d/%0b", k, cnt2, rdy2, q2.size(), q2.size() < 2);
            end else npass++;
        end
        nchk++; if (q2.size() != 2 || cnt2 !== 2'd2 || rdy2 !== 1'b0) begin
            $display("FAIL fill_full cnt=%0d rdy=%0b want 2/0", cnt2, rdy2);
        end else npass++;
        ihit2 = 1'b0;
        stall = 1'b0;
        nchk++; if (instr2 !== words[0] || pc2 !== 32'h100) begin
            $display("FAIL fill_a instr=%h pcp4=%h want %h/100", instr2, pc2, words[0]);
        end else npass++;
        tick();
        nchk++; if (instr2 !== words[1] || pc2 !== 32'h104 || rdy2 !== 1'b1) begin
            $display("FAIL fill_b instr=%h pcp4=%h rdy=%0b want %h/104/1", instr2, pc2, rdy2, words[1]);
        end else npass++;
        tick();
        nchk++; if (vld2 !== 1'b0 || instr2 !== 32'h0 || pc2 !== 32'h0) begin
            $display("FAIL fill_c_dropped vld=%0b instr=%h pcp4=%h want 0/0/0", vld2, instr2, pc2);
        end else npass++;
    endtask

    task automatic test_wrap();
        logic [63:0] h;
        int idx = 0;
        int nout = 0;
        int cyc = 0;
        while (nout < 10 && cyc < 200) begin
            stall = (cyc < 6) || (cyc % 3 == 0);
            ihit4 = (idx < 10);
            imemload = 32'h4000_0000 + idx;
            pcp4_in = 32'h1000 + 32'd4 * idx;
            nchk++; if (vld4 !== (q4.size() != 0) || cnt4 !== 3'(q4.size()) || cnt4 > 3'd4) begin
                $display("FAIL wrap_cnt cyc=%0d vld=%0b cnt=%0d want %0b/%0d", cyc, vld4, cnt4, q4.size() != 0, q4.size());
            end else npass++;
            if (q4.size() != 0) begin
                h = q4[0];
                nchk++; if (instr4 !== h[63:32] || pc4 !== h[31:0]) begin
                    $display("FAIL wrap_order cyc=%0d instr=%h pcp4=%h want %h/%h", cyc, instr4, pc4, h[63:32], h[31:0]);
                end else npass++;
                if (!stall) nout++;
            end
            if (ihit4 && q4.size() < 4) idx++;
            tick();
            cyc++;
        end
        nchk++; if (nout != 10 || idx != 10) begin
            $display("FAIL wrap_timeout delivered=%0d accepted=%0d want 10/10", nout, idx);
        end else npass++;
        ihit4 = 1'b0;
        stall = 1'b0;
        nchk++; if (vld4 !== 1'b0 || instr4 !== 32'h0) begin
            $display("FAIL wrap_empty vld=%0b instr=%h want 0/0", vld4, instr4);
        end else npass++;
    endtask

    task automatic test_flush();
        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            ihit2 = 1'b1;
            imemload = 32'h5500_0000 + k;
            pcp4_in = 32'h200 + 32'd4 * k;
            tick();
        end
        nchk++; if (cnt2 !== 2'd2) begin
            $display("FAIL flush_prefill cnt=%0d want 2", cnt2);
        end else npass++;
        flush = 1'b1;
        stall = 1'b0;
        ihit2 = 1'b1;
        imemload = 32'hDDDD_DDDD;
        pcp4_in = 32'h300;
        tick();
        flush = 1'b0;
        ihit2 = 1'b0;
        nchk++; if (cnt2 !== 2'd0 || vld2 !== 1'b0 || instr2 !== 32'h0 || pc2 !== 32'h0 || rdy2 !== 1'b1) begin
            $display("FAIL flush_next cnt=%0d vld=%0b instr=%h pcp4=%h rdy=%0b want 0/0/0/0/1", cnt2, vld2, instr2, pc2, rdy2);
        end else npass++;
        repeat (2) tick();
        nchk++; if (vld2 !== 1'b0 || instr2 === 32'hDDDD_DDDD) begin
            $display("FAIL flush_d_gone vld=%0b instr=%h want 0/0", vld2, instr2);
        end else npass++;
    endtask

    task automatic test_async_reset();
        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            ihit2 = 1'b1;
            imemload = 32'h6600_0000 + k;
            pcp4_in = 32'h400 + 32'd4 * k;
            tick();
        end
        ihit2 = 1'b0;
        nchk++; if (cnt2 !== 2'd2 || vld2 !== 1'b1) begin
            $display("FAIL arst_prefill cnt=%0d vld=%0b want 2/1", cnt2, vld2);
        end else npass++;
        #1 nRST = 1'b0;
        #1;
        q2.delete();
        q4.delete();
        nchk++; if (cnt2 !== 2'd0 || vld2 !== 1'b0 || rdy2 !== 1'b1 || instr2 !== 32'h0 || pc2 !== 32'h0) begin
            $display("FAIL arst_immediate cnt=%0d vld=%0b rdy=%0b instr=%h pcp4=%h want 0/0/1/0/0", cnt2, vld2, rdy2, instr2, pc2);
        end else npass++;
        #1 nRST = 1'b1;
        stall = 1'b0;
        tick();
        ihit2 = 1'b1;
        imemload = 32'hEEEE_0001;
        pcp4_in = 32'h500;
        tick();
        ihit2 = 1'b0;
        nchk++; if (vld2 !== 1'b1 || instr2 !== 32'hEEEE_0001 || pc2 !== 32'h500 || cnt2 !== 2'd1) begin
            $display("FAIL arst_first instr=%h pcp4=%h vld=%0b cnt=%0d want eeee0001/500/1/1", instr2, pc2, vld2, cnt2);
        end else npass++;
        tick();
        nchk++; if (vld2 !== 1'b0) begin
            $display("FAIL arst_only_one vld=%0b want 0", vld2);
        end else npass++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall_fill();
        test_wrap();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
